// File: rtl/dcache_2way_ctrl.sv
// Two-way set-associative write-back, write-allocate data cache controller.
// Tag/valid/dirty/LRU/data live in register arrays so lookups resolve in the request cycle.
module dcache_2way_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int LINE_BITS = 256,
   parameter int SETS      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADDR_W-1:0]    p1_addr_i,
   input  logic [31:0]          p1_data_i,
   input  logic                 p1_MemRead_i,
   input  logic                 p1_MemWrite_i,
   output logic [31:0]          p1_data_o,
   output logic                 p1_stall_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          access_cnt_o,
   output logic [31:0]          miss_cnt_o
);
   localparam int OFF_W  = $clog2(LINE_BITS / 8);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int WSEL_W = OFF_W - 2;

   typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILLOK} state_e;
   state_e state_q, state_d;

   logic [TAG_W-1:0]     tag_q   [2][SETS];
   logic [LINE_BITS-1:0] line_q  [2][SETS];
   logic [SETS-1:0]      valid_q [2];
   logic [SETS-1:0]      dirty_q [2];
   logic [SETS-1:0]      lru_q;

   logic             victim_q, victim_d;
   logic [TAG_W-1:0] victim_tag_q;
   logic             victim_dirty_q;
   logic [31:0]      access_q, miss_q;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WSEL_W-1:0] req_word;
   logic [OFF_W+2:0]  bit_off;
   logic              unused_addr;
   logic              req, hit0, hit1, hit, hit_way;
   logic              access_hit, miss_det;
   logic [LINE_BITS-1:0] hit_line;

   assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
   assign req_idx     = p1_addr_i[OFF_W +: IDX_W];
   assign req_word    = p1_addr_i[2 +: WSEL_W];
   assign bit_off     = {req_word, 5'd0};
   assign unused_addr = ^p1_addr_i[1:0];

   assign req        = p1_MemRead_i | p1_MemWrite_i;
   assign hit0       = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
   assign hit1       = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
   assign hit        = hit0 | hit1;
   assign hit_way    = ~hit0;
   assign hit_line   = hit0 ? line_q[0][req_idx] : line_q[1][req_idx];
   assign access_hit = (state_q == IDLE) && req && hit;
   assign miss_det   = (state_q == IDLE) && req && !hit;

   // Empty ways are filled before anything is evicted; way 0 preferred.
   assign victim_d = !valid_q[0][req_idx] ? 1'b0 :
                     !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (miss_det) state_d = MISS;
         MISS:      state_d = victim_dirty_q ? WRITEBACK : REFILL;
         WRITEBACK: if (mem_ack_i) state_d = REFILL;
         REFILL:    if (mem_ack_i) state_d = REFILLOK;
         REFILLOK:  state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = {req_tag, req_idx, {OFF_W{1'b0}}};
      case (state_q)
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {victim_tag_q, req_idx, {OFF_W{1'b0}}};
         end
         REFILL:  mem_enable_o = 1'b1;
         default: ;
      endcase
      p1_stall_o = req && !access_hit;
      p1_data_o  = access_hit ? hit_line[bit_off +: 32] : '0;
   end

   // Victim line is stable while the request is held, so this needs no register.
   assign mem_data_o   = line_q[victim_q][req_idx];
   assign access_cnt_o = access_q;
   assign miss_cnt_o   = miss_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q[0]     <= '0;
         valid_q[1]     <= '0;
         dirty_q[0]     <= '0;
         dirty_q[1]     <= '0;
         lru_q          <= '0;
         access_q       <= '0;
         miss_q         <= '0;
         victim_q       <= 1'b0;
         victim_tag_q   <= '0;
         victim_dirty_q <= 1'b0;
      end else begin
         if (access_hit) begin
            lru_q[req_idx] <= ~hit_way;
            access_q       <= access_q + 32'd1;
            if (p1_MemWrite_i) dirty_q[hit_way][req_idx] <= 1'b1;
         end
         if (miss_det) begin
            miss_q         <= miss_q + 32'd1;
            victim_q       <= victim_d;
            victim_tag_q   <= tag_q[victim_d][req_idx];
            victim_dirty_q <= valid_q[victim_d][req_idx] & dirty_q[victim_d][req_idx];
         end
         if (state_q == WRITEBACK && mem_ack_i) dirty_q[victim_q][req_idx] <= 1'b0;
         if (state_q == REFILL && mem_ack_i) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (access_hit && p1_MemWrite_i) line_q[hit_way][req_idx][bit_off +: 32] <= p1_data_i;
      if (state_q == REFILL && mem_ack_i) begin
         line_q[victim_q][req_idx] <= mem_data_i;
         tag_q[victim_q][req_idx]  <= req_tag;
      end
   end
endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Directed bench for dcache_2way_ctrl: default geometry plus a LINE_BITS=128/SETS=64 instance.
module tb_dcache_2way_ctrl;
   logic clk, rst;
   logic [31:0]  addr, wdata, p1_data, acc, miss;
   logic         rd, wr, stall, ack, en, we;
   logic [255:0] mem_rdata, mem_wdata;
   logic [31:0]  mem_addr;

   logic [31:0]  q_addr, q_wdata, q_p1_data, q_acc, q_miss, q_mem_addr;
   logic         q_rd, q_wr, q_stall, q_ack, q_en, q_we;
   logic [127:0] q_mem_rdata, q_mem_wdata;

   int checks = 0;
   int errors = 0;

   dcache_2way_ctrl #(.ADDR_W(32), .LINE_BITS(256), .SETS(16)) u_dut (
      .clk_i(clk), .rst_i(rst), .p1_addr_i(addr), .p1_data_i(wdata),
      .p1_MemRead_i(rd), .p1_MemWrite_i(wr), .p1_data_o(p1_data), .p1_stall_o(stall),
      .mem_data_i(mem_rdata), .mem_ack_i(ack), .mem_data_o(mem_wdata), .mem_addr_o(mem_addr),
      .mem_enable_o(en), .mem_write_o(we), .access_cnt_o(acc), .miss_cnt_o(miss));

   dcache_2way_ctrl #(.ADDR_W(32), .LINE_BITS(128), .SETS(64)) u_p (
      .clk_i(clk), .rst_i(rst), .p1_addr_i(q_addr), .p1_data_i(q_wdata),
      .p1_MemRead_i(q_rd), .p1_MemWrite_i(q_wr), .p1_data_o(q_p1_data), .p1_stall_o(q_stall),
      .mem_data_i(q_mem_rdata), .mem_ack_i(q_ack), .mem_data_o(q_mem_wdata), .mem_addr_o(q_mem_addr),
      .mem_enable_o(q_en), .mem_write_o(q_we), .access_cnt_o(q_acc), .miss_cnt_o(q_miss));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [255:0] mkline(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
      return l;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drop();
      @(negedge clk);
      rd = 1'b0;
      wr = 1'b0;
   endtask

   // Drive a missing request; checks the detect cycle and the MISS cycle.
   task automatic miss_start(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d);
      addr = a; wr = w; rd = !w; wdata = d;
      #1;
      chk({tag, "_detect_stall"}, stall, 1);
      @(negedge clk);
      chk({tag, "_miss_stall"}, stall, 1);
      chk({tag, "_miss_en"}, en, 0);
   endtask

   // Serve one memory transaction, acking in the n-th cycle of mem_enable.
   task automatic mem_txn(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                          input int n, input logic [255:0] line, input logic [63:0] exp_wb);
      int i;
      i = 0;
      while (!en && i < 16) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "_en"}, en, 1);
      chk({tag, "_we"}, we, exp_we);
      chk({tag, "_addr"}, mem_addr, exp_addr);
      if (exp_we) chk({tag, "_wbdata"}, mem_wdata[63:0], exp_wb);
      repeat (n - 1) @(negedge clk);
      mem_rdata = line;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   // Called in REFILLOK; the next cycle must be a hit.
   task automatic fill_done(input string tag, input logic is_rd, input logic [31:0] exp);
      chk({tag, "_ok_stall"}, stall, 1);
      chk({tag, "_ok_en"}, en, 0);
      @(negedge clk);
      chk({tag, "_hit_stall"}, stall, 0);
      if (is_rd) chk({tag, "_hit_data"}, p1_data, exp);
   endtask

   task automatic hit(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [31:0] exp);
      addr = a; wr = w; rd = !w; wdata = d;
      #1;
      chk({tag, "_stall"}, stall, 0);
      chk({tag, "_en"}, en, 0);
      if (!w) chk({tag, "_data"}, p1_data, exp);
   endtask

   task automatic q_read_miss(input string tag, input logic [31:0] a, input logic [31:0] exp_addr,
                              input logic [127:0] line, input logic [31:0] exp);
      q_addr = a; q_rd = 1'b1;
      #1;
      chk({tag, "_detect_stall"}, q_stall, 1);
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_en"}, q_en, 1);
      chk({tag, "_addr"}, q_mem_addr, exp_addr);
      q_mem_rdata = line;
      q_ack = 1'b1;
      @(negedge clk);
      q_ack = 1'b0;
      chk({tag, "_ok_stall"}, q_stall, 1);
      @(negedge clk);
      chk({tag, "_hit_stall"}, q_stall, 0);
      chk({tag, "_hit_data"}, q_p1_data, exp);
      @(negedge clk);
      q_rd = 1'b0;
   endtask

   initial begin
      logic [255:0] tmp;
      rst = 1'b1; ack = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; mem_rdata = '0;
      q_ack = 1'b0; q_rd = 1'b0; q_wr = 1'b0; q_addr = '0; q_wdata = '0; q_mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_en", en, 0);
      chk("rst_we", we, 0);
      chk("rst_stall", stall, 0);
      chk("rst_data", p1_data, 0);
      chk("rst_acc", acc, 0);
      chk("rst_miss", miss, 0);

      // Cold read miss, ack in third refill cycle
      miss_start("s1", 32'h40, 1'b0, 32'h0);
      mem_txn("s1_rf", 1'b0, 32'h40, 3, mkline(32'h1111_2222), 64'h0);
      fill_done("s1", 1'b1, 32'h1111_2222);
      chk("s1_misscnt", miss, 1);
      drop();
      chk("s1_acccnt", acc, 1);

      // Same set, second tag fills way 1; 0x040 must still hit
      miss_start("s2", 32'h240, 1'b0, 32'h0);
      mem_txn("s2_rf", 1'b0, 32'h240, 1, mkline(32'h2222_0000), 64'h0);
      fill_done("s2", 1'b1, 32'h2222_0000);
      drop();
      hit("s2_re040", 32'h40, 1'b0, 32'h0, 32'h1111_2222);
      drop();

      // Dirty eviction of way 0 after 0x240 becomes MRU
      hit("s3_wr040", 32'h40, 1'b1, 32'hDEAD_BEEF, 32'h0);
      drop();
      hit("s3_rd240", 32'h240, 1'b0, 32'h0, 32'h2222_0000);
      drop();
      miss_start("s3", 32'h440, 1'b0, 32'h0);
      mem_txn("s3_wb", 1'b1, 32'h40, 2, '0, {32'h1111_2223, 32'hDEAD_BEEF});
      mem_txn("s3_rf", 1'b0, 32'h440, 1, mkline(32'h4444_0000), 64'h0);
      fill_done("s3", 1'b1, 32'h4444_0000);
      drop();
      hit("s3_re240", 32'h240, 1'b0, 32'h0, 32'h2222_0000);
      drop();
      chk("s3_acccnt", acc, 7);
      chk("s3_misscnt", miss, 3);

      // Reset pulsed during refill; late ack must be ignored
      miss_start("s5", 32'h40, 1'b0, 32'h0);
      @(negedge clk);
      chk("s5_refill_en", en, 1);
      #1;
      rst = 1'b1;
      rd = 1'b0;
      #1;
      chk("s5_rst_en", en, 0);
      @(negedge clk);
      rst = 1'b0;
      mem_rdata = mkline(32'h9999_0000);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("s5_late_en", en, 0);
      chk("s5_late_stall", stall, 0);
      chk("s5_acccnt", acc, 0);
      chk("s5_misscnt", miss, 0);
      addr = 32'h40; rd = 1'b1;
      #1;
      chk("s5_remiss_stall", stall, 1);
      @(negedge clk);
      rst = 1'b1;
      rd = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Write-miss allocate, then evict the dirtied line through set 3
      miss_start("s4", 32'h64, 1'b1, 32'h0000_00AB);
      mem_txn("s4_rf", 1'b0, 32'h60, 1, mkline(32'h6060_0000), 64'h0);
      fill_done("s4", 1'b0, 32'h0);
      drop();
      hit("s4_rd064", 32'h64, 1'b0, 32'h0, 32'h0000_00AB);
      drop();
      miss_start("s4b", 32'h264, 1'b0, 32'h0);
      mem_txn("s4b_rf", 1'b0, 32'h260, 1, mkline(32'h6262_0000), 64'h0);
      fill_done("s4b", 1'b1, 32'h6262_0001);
      drop();
      miss_start("s4c", 32'h464, 1'b0, 32'h0);
      mem_txn("s4c_wb", 1'b1, 32'h60, 1, '0, {32'h0000_00AB, 32'h6060_0000});
      mem_txn("s4c_rf", 1'b0, 32'h460, 1, mkline(32'h6464_0000), 64'h0);
      fill_done("s4c", 1'b1, 32'h6464_0001);
      drop();
      chk("s4_acccnt", acc, 4);
      chk("s4_misscnt", miss, 3);

      // 128-bit lines, 64 sets: 0x048 is set 4 word 2, 0x440 is set 4 tag 1
      tmp = mkline(32'h5555_0000);
      q_read_miss("p_048", 32'h48, 32'h40, tmp[127:0], 32'h5555_0002);
      tmp = mkline(32'h5656_0000);
      q_read_miss("p_440", 32'h440, 32'h440, tmp[127:0], 32'h5656_0000);
      q_addr = 32'h48; q_rd = 1'b1;
      #1;
      chk("p_re048_stall", q_stall, 0);
      chk("p_re048_data", q_p1_data, 32'h5555_0002);
      @(negedge clk);
      q_rd = 1'b0;
      chk("p_acccnt", q_acc, 3);
      chk("p_misscnt", q_miss, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dcache_2way_ctrl.md
# dcache_2way_ctrl

Two-way set-associative, write-back, write-allocate data cache that replaces the direct-mapped data cache between the pipeline MEM stage and the line-wide data memory. Tag, valid, dirty, LRU and data storage are internal register arrays, so a lookup completes in the same cycle. Line width and set count are parameters. The block adds per-set LRU replacement, invalid-way-first allocation and access/miss counters.

## Interface
- ADDR_W, 32, byte address width
- LINE_BITS, 256, line width in bits; power of two, at least 64
- SETS, 16, sets per way; power of two, at least 2
- Derived: OFF_W=log2(LINE_BITS/8), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, WORDS=LINE_BITS/32
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- p1_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- p1_data_i  in  32  store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request; never asserted together with p1_MemRead_i
- p1_data_o  out  32  load data; 0 when not (request and hit)
- p1_stall_o  out  1  request and not hit
- mem_data_i  in  LINE_BITS  refill line; valid in the mem_ack_i cycle
- mem_ack_i  in  1  one-cycle completion pulse
- mem_data_o  out  LINE_BITS  victim line for write-back
- mem_addr_o  out  ADDR_W  line-aligned address; low OFF_W bits are 0
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1 = write-back, 0 = refill
- access_cnt_o  out  32  completed accesses, wraps
- miss_cnt_o  out  32  misses, wraps

## Operation
- Address split: tag = [ADDR_W-1:IDX_W+OFF_W], index = [IDX_W+OFF_W-1:OFF_W], word = [OFF_W-1:2]. Word 0 occupies line bits [31:0].
- Hit: way w is valid and its tag equals the request tag. If both ways match, that is a design error; way 0 wins.
- Read hit: p1_data_o is the selected word, same cycle. LRU[set] is set to the other way.
- Write hit: the word is written into the hit way at the clock edge and dirty is set. Other words are unchanged. LRU is updated.
- Victim selection, latched on IDLE->MISS:
  - Invalid way 0 first, then invalid way 1, else way LRU[set].
  - The victim way, its tag and its dirty bit are latched.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILLOK.
  - IDLE: if request and not hit, go to MISS and increment miss_cnt_o.
  - MISS: if the victim is valid and dirty, go to WRITEBACK with mem_enable=1, mem_write=1, addr={victim tag, index, 0}, mem_data_o=victim line. Otherwise go to REFILL with mem_enable=1, mem_write=0, addr={request tag, index, 0}.
  - WRITEBACK: on ack, clear the victim dirty bit and go to REFILL with mem_write=0 and the refill address. mem_enable stays high through the transition.
  - REFILL: on ack, write mem_data_i, the tag and valid=1 into the victim way with dirty=0, drop mem_enable, and go to REFILLOK.
  - REFILLOK: go to IDLE. The held request then hits. A store completes as a write hit in that cycle.
- access_cnt_o increments on every IDLE cycle with request and hit, including the hit after a refill. Hits = access - miss.
- The request (address, data, read/write) stays stable while p1_stall_o=1. The block does not re-latch it.
- mem_ack_i outside WRITEBACK or REFILL is ignored.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE, mem_enable_o=0, mem_write_o=0.
  - All valid, dirty and LRU bits are 0. Counters are 0.
  - Data and tag arrays are not cleared.
  - Any in-flight memory transaction is abandoned; a late ack is ignored.
- mem_addr_o and mem_data_o are registered or held constant while mem_enable_o=1.
- Clean miss, ack arriving N cycles after mem_enable rises (N>=1):
  - stall asserted for N+3 cycles: IDLE detect, MISS, REFILL×N, REFILLOK.
  - Hit in the following IDLE cycle.
- Dirty miss: writeback latency and refill latency add serially, plus the MISS and REFILLOK cycles.
- Hits: zero stall, one access per cycle.

## Test plan
- Read miss, defaults: read 0x0000_0040 on a cold cache. mem_enable_o=1, mem_write_o=0, mem_addr_o=0x40. Ack after 3 cycles with word0=0x1111_2222. Stall falls 2 cycles after ack; p1_data_o=0x1111_2222; miss=1, access=1.
- Invalid-first fill: read 0x040 then 0x240 (both set 2). The second fills way 1, no write-back. Re-reading 0x040 hits with zero stall.
- Dirty eviction: write 0xDEAD_BEEF to 0x040, read 0x240, read 0x440.
  - Victim is way 0 (LRU). Write-back uses mem_addr_o=0x040 and mem_data_o[31:0]=0xDEAD_BEEF, then refill of 0x440.
  - Re-reading 0x240 hits.
- Write miss allocate: write 0x0000_00AB to 0x064 on a cold cache. After refill, line word 1 = 0xAB and dirty=1. A later read of 0x064 returns 0xAB without memory traffic.
- Reset mid-refill: pulse rst_i during REFILL. mem_enable_o falls immediately and a late ack is ignored. A re-read of 0x040 misses again; counters read 0.
- Parameter sweep: LINE_BITS=128, SETS=64. Same scenarios with the correct index/offset split, e.g. 0x040 maps to set 4.
